serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer that time-shares a single 1-bit full-adder cell across a WIDTH-bit operation. The full-adder cell is built from two half-adder cells plus an OR of their carries. The block latches two operands on a start handshake, feeds one bit pair per clock (LSB first), and accumulates the sum and carry. It holds the result under a done/ack handshake. It sits between a requesting control FSM and the shared adder cell, trading latency for area in small arithmetic paths.

---
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused for WIDTH clocks, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub_in,
`endif
    input  logic             ack_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic [1:0]       state_dbg
);

    // Handshakes: a request is accepted on the rising edge where start_in=1 and
    // ready_out=1; a result is released on the rising edge where ack_in=1 and done_out=1.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             c;

    // Full adder built from two half adders plus an OR of their carries.
    logic ha1_s, ha1_c, ha2_s, ha2_c, fa_s, fa_c;
    always_comb begin
        ha1_s = opa[0] ^ opb[0];
        ha1_c = opa[0] & opb[0];
        ha2_s = ha1_s ^ c;
        ha2_c = ha1_s & c;
        fa_s  = ha2_s;
        fa_c  = ha1_c | ha2_c;
    end

    logic [WIDTH-1:0] res_next;
    assign res_next  = {fa_s, res[WIDTH-1:1]};
    assign state_dbg = state;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            cnt       <= '0;
            c         <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        opa <= a_in;
`ifdef SERIAL_ADD_SUB_EN
                        // Subtract as A + ~B + 1; carry_out=1 then means no borrow.
                        opb <= sub_in ? ~b_in : b_in;
                        c   <= sub_in;
`else
                        opb <= b_in;
                        c   <= 1'b0;
`endif
                        cnt       <= '0;
                        state     <= RUN;
                        ready_out <= 1'b0;
                        busy_out  <= 1'b1;
                    end
                end
                RUN: begin
                    c   <= fa_c;
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    res <= res_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_out   <= res_next;
                        carry_out <= fa_c;
                        state     <= HOLD;
                        busy_out  <= 1'b0;
                        done_out  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (ack_in) begin
                        state     <= IDLE;
                        done_out  <= 1'b0;
                        ready_out <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ready_out <= 1'b1;
                    busy_out  <= 1'b0;
                    done_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, corner sequences, random ops
// checked against an arithmetic reference model through an expected-result queue.
module tb_serial_add_ctrl;

    localparam int W = 8;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_in, start_in, ack_in, sub_in;
    logic [W-1:0] a_in, b_in;
    logic         ready_out, busy_out, done_out, carry_out;
    logic [W-1:0] sum_out;
    logic [1:0]   state_dbg;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_in    (clk),
        .rst_in    (rst_in),
        .start_in  (start_in),
        .a_in      (a_in),
        .b_in      (b_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub_in    (sub_in),
`endif
        .ack_in    (ack_in),
        .ready_out (ready_out),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept = 0;
    logic [W:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic, result packed as {carry, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
        logic [W:0] r;
        if (sub) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b};
        end
        return r;
    endfunction

    // driver: one complete operation, optional hold delay and start pulses while not ready
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input int hold_cycles, input bit pulse);
        int busy_cnt;
        int waited;
        logic [W:0] exp;
        check("ready_before_start", ready_out, 1);
        a_in = a; b_in = b; sub_in = sub; start_in = 1'b1;
        exp_q.push_back(model(a, b, sub));
        tick();
        last_accept = cyc;
        start_in = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); sub_in = 1'($urandom);
        busy_cnt = 0;
        waited = 0;
        while (!done_out && waited < W + 4) begin
            check("onehot_run", 32'(ready_out) + 32'(busy_out) + 32'(done_out), 1);
            if (busy_out) busy_cnt++;
            start_in = pulse && (waited == 2);
            if (pulse) a_in = 8'hAA;
            tick();
            waited++;
        end
        start_in = 1'b0;
        check("done_seen", done_out, 1);
        check("latency", waited, W);
        check("busy_cycles", busy_cnt, W);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("sum", sum_out, exp[W-1:0]);
        check("carry", carry_out, exp[W]);
        for (int i = 0; i < hold_cycles; i++) begin
            start_in = pulse && (i == 0);
            a_in = 8'hAA;
            tick();
            check("hold_done", done_out, 1);
            check("hold_sum", sum_out, exp[W-1:0]);
            check("hold_carry", carry_out, exp[W]);
        end
        start_in = 1'b0;
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("ack_ready", ready_out, 1);
        check("ack_done", done_out, 0);
        check("retain_sum", sum_out, exp[W-1:0]);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
        int           hold;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int first_accept;
        vec_t v;

        vecs.push_back('{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 5});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 2});
        vecs.push_back('{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 0});
        vecs.push_back('{8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 0});
        vecs.push_back('{8'h42, 8'h42, 1'b1, 8'h00, 1'b1, 0});
`endif

        rst_in = 1'b1; start_in = 1'b0; ack_in = 1'b0; sub_in = 1'b0;
        a_in = '0; b_in = '0;
        repeat (2) tick();
        check("rst_ready", ready_out, 1);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_sum", sum_out, 0);
        check("rst_carry", carry_out, 0);
        rst_in = 1'b0;
        tick();

        // ack outside HOLD has no effect
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("idle_ack_ready", ready_out, 1);
        check("idle_ack_done", done_out, 0);

        // table-driven vectors, each checked against its constant expectation
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            exp_q.push_back({v.exp_carry, v.exp_sum});
            do_op(v.a, v.b, v.sub, v.hold, 1'b0);
            check("table_vs_model", exp_q.pop_front(), model(v.a, v.b, v.sub));
            check("table_sum", sum_out, v.exp_sum);
            check("table_carry", carry_out, v.exp_carry);
        end

        // back-to-back issue: ack on first done cycle, start on the next edge
        do_op(8'h35, 8'h4A, 1'b0, 0, 1'b0);
        first_accept = last_accept;
        do_op(8'h10, 8'h20, 1'b0, 0, 1'b0);
        check("b2b_interval", last_accept - first_accept, W + 2);
        check("b2b_sum", sum_out, 8'h30);

        // start pulses during RUN and HOLD are ignored
        do_op(8'h12, 8'h34, 1'b0, 2, 1'b1);
        tick();
        check("pulse_no_extra_done", done_out, 0);
        check("pulse_idle_ready", ready_out, 1);

        // reset on the 4th RUN cycle aborts and exposes only reset values
        a_in = 8'h77; b_in = 8'h11; sub_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (3) tick();
        check("mid_run_busy", busy_out, 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("abort_ready", ready_out, 1);
        check("abort_busy", busy_out, 0);
        check("abort_done", done_out, 0);
        check("abort_sum", sum_out, 0);
        check("abort_carry", carry_out, 0);
        tick();

        // reset during HOLD
        a_in = 8'h01; b_in = 8'h02; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (W) tick();
        check("hold_reached", done_out, 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("hold_abort_done", done_out, 0);
        check("hold_abort_sum", sum_out, 0);
        tick();

        // randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            logic sub_r;
`ifdef SERIAL_ADD_SUB_EN
            sub_r = 1'($urandom);
`else
            sub_r = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), sub_r, $urandom_range(0, 3),
                  1'($urandom));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
